tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Game-timing controller for Flappy-VGA. It owns the design's single free-running timebase. It issues one-cycle clock-enable strobes (pixel, game, move, pace) and the seven-segment digit select, all in the `clk` domain, so no logic needs a derived clock. A four-state game FSM (idle/run/pause/over) gates the game and move strobes, which freezes world motion when the game is paused or ended.

## Interface
Parameters:
- `PIX_LOG2`, 2: log2 of the pixel strobe period, in `clk` cycles.
- `SEG_LOG2`, 18: log2 of the dwell time of each seven-segment digit.
- `GAME_LOG2`, 20: log2 of the game-logic strobe period.
- `MOVE_LOG2`, 21: log2 of the base move strobe period. Must be ≥ 4.
- `PACE_LOG2`, 26: log2 of the pace (blink) strobe period.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle start/restart pulse from the debounced button.
- `pause` in 1: single-cycle pause-toggle pulse.
- `collide` in 1: collision detected. Level or pulse.
- `speed` in 2: move speedup; the effective move period is 2^(MOVE_LOG2−speed).
- `pix_tick` out 1: pixel enable strobe.
- `game_tick` out 1: game-logic enable strobe.
- `move_tick` out 1: scroll/move enable strobe.
- `pace_tick` out 1: pace/blink enable strobe.
- `seg_sel` out 2: seven-segment digit index.
- `restart` out 1: one-cycle pulse telling game state to clear.
- `state` out 2: game state, encoded IDLE=0, RUN=1, PAUSE=2, OVER=3.

## Operation
- **Free counter `fcnt`** (32 bits):
  - Increments every cycle; wraps modulo 2^32.
  - Is never gated by the FSM.
- **Run counter `rcnt`** (32 bits):
  - Increments only in cycles where `state`==RUN.
  - Clears to 0 on every transition into RUN from IDLE or OVER.
  - Holds its value in PAUSE, so resuming keeps the strobe phase.
- **Strobes** are registered. Each is high in the cycle after its counter's low N bits equal all-ones:
  - `pix_tick`: N=PIX_LOG2, from `fcnt`, always active.
  - `pace_tick`: N=PACE_LOG2, from `fcnt`, always active.
  - `game_tick`: N=GAME_LOG2, from `rcnt`, qualified by `state`==RUN in the compare cycle.
  - `move_tick`: N=MOVE_LOG2−`speed`, from `rcnt`, qualified by `state`==RUN in the compare cycle. `speed` is sampled every cycle, so a change applies from the next compare.
- **`seg_sel`** = `fcnt[SEG_LOG2+1:SEG_LOG2]`, taken directly from the register.
- **FSM transitions**; an unlisted input holds the current state:
  - IDLE: `start` → RUN. `pause` and `collide` are ignored.
  - RUN: `collide` → OVER. Otherwise `pause` → PAUSE. `start` is ignored.
  - PAUSE: `pause` → RUN. `collide` and `start` are ignored. `restart` is not asserted.
  - OVER: `start` → RUN. `pause` is ignored.
  - Priority in RUN: `collide` > `pause`.
- **`restart`**:
  - High for exactly the first cycle in RUN after entry from IDLE or OVER.
  - Never asserted on resume from PAUSE.
- **Reset (`rst`=1)**, including mid-game:
  - At the next edge: `fcnt`=0, `rcnt`=0, `state`=IDLE.
  - All strobes and `restart` are 0.
  - `seg_sel`=0.

## Timing
- **Cycle numbering:** cycle 0 is the first cycle with `rst` low, with `fcnt`=0.
- **`pix_tick`** is high in cycles k·2^PIX_LOG2 for k ≥ 1, exactly one cycle wide. The same rule applies to `pace_tick`.
- **Start timing:** a `start` sampled in cycle s puts `state`=RUN, `rcnt`=0 and `restart`=1 in cycle s+1.
  - The first `game_tick` is high in cycle s+1+2^GAME_LOG2.
  - The first `move_tick` is high in cycle s+1+2^(MOVE_LOG2−speed).
- **Gated-strobe latency:** 1 cycle from the `rcnt` compare, the same as the free strobes.
- **Exit edge case:** if `collide` or `pause` arrives in the same cycle as a RUN compare hit, that strobe still fires in the next cycle, while `state` is already OVER or PAUSE. No further gated strobes follow.
- **Pause/resume:** a PAUSE of P cycles delays every subsequent gated strobe by exactly P cycles.
- **Wrap:** `fcnt` wrap at 2^32 is seamless. The strobe period is unaffected because 2^N divides 2^32.
- **State updates** land at the edge after the input is sampled. Each input event causes exactly one transition.

## Test plan
Test parameters: PIX_LOG2=2, SEG_LOG2=3, GAME_LOG2=4, MOVE_LOG2=5, PACE_LOG2=6.
- **Reset and free strobes.** Release reset and run 128 cycles.
  - `pix_tick` is high in cycles 4, 8, 12, …
  - `pace_tick` is high in cycles 64 and 128.
  - `seg_sel` steps 0→1→2→3 every 8 cycles.
  - `state`=0 throughout, and `game_tick`/`move_tick` stay 0.
- **Start.** Pulse `start` in cycle 10 with `speed`=0.
  - Cycle 11: `state`=1 and `restart`=1 for one cycle.
  - `game_tick` is high in cycles 27, 43, …
  - `move_tick` is high in cycles 43, 75, …
- **Pause/resume.** From RUN, pulse `pause` 3 cycles before a `game_tick` is due, hold PAUSE for 20 cycles, then pulse `pause` again.
  - No gated strobes occur during PAUSE.
  - The next `game_tick` arrives 20+1 cycles later than it would have without the pause.
  - `restart` stays 0.
- **Collide priority.** In RUN, assert `collide` and `pause` in the same cycle.
  - Next cycle: `state`=3.
  - Pulse `start`: `state`=1, `restart`=1, and `rcnt` restarts (first `game_tick` 16 cycles later).
- **Speed.** In RUN with `speed`=3, `move_tick` period is 4 cycles. Switching to `speed`=1 gives a period of 16 cycles from the next compare.
- **Mid-game reset.** Assert `rst` for 1 cycle while in RUN.
  - All outputs are 0 and `state`=0 next cycle.
  - The free-strobe schedule restarts from cycle 0.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Control inputs and strobe outputs of the game timebase, bundled for one port.
interface tick_scheduler_if;
    logic       start;
    logic       pause;
    logic       collide;
    logic [1:0] speed;
    logic       pix_tick;
    logic       game_tick;
    logic       move_tick;
    logic       pace_tick;
    logic [1:0] seg_sel;
    logic       restart;
    logic [1:0] state;

    // Scheduler side: consumes control pulses, drives strobes and state.
    modport slave (
        input  start, pause, collide, speed,
        output pix_tick, game_tick, move_tick, pace_tick, seg_sel, restart, state
    );

    // Game-logic side: drives control pulses, consumes strobes and state.
    modport master (
        output start, pause, collide, speed,
        input  pix_tick, game_tick, move_tick, pace_tick, seg_sel, restart, state
    );
endinterface

// File: rtl/tick_scheduler.sv
// Single free-running timebase for Flappy-VGA: clock-enable strobes, digit
// select and the idle/run/pause/over game FSM that gates world motion.
module tick_scheduler #(
    parameter int unsigned PIX_LOG2  = 2,
    parameter int unsigned SEG_LOG2  = 18,
    parameter int unsigned GAME_LOG2 = 20,
    parameter int unsigned MOVE_LOG2 = 21,
    parameter int unsigned PACE_LOG2 = 26
) (
    input  logic              clk,
    input  logic              rst,
    tick_scheduler_if.slave   bus
);
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               restart_d;
    logic [CNT_W-1:0]   fcnt;
    logic [CNT_W-1:0]   rcnt;
    logic               pix_q;
    logic               pace_q;
    logic               game_q;
    logic               move_q;
    logic               restart_q;
    logic [SHIFT_W-1:0] move_n_c;
    logic [CNT_W-1:0]   move_mask_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; restart flags a fresh game (entry to RUN not from PAUSE).
    always_comb begin
        state_d   = state_q;
        restart_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    restart_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.collide) begin
                    state_d = OVER;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.pause) begin
                    state_d = RUN;
                end
            end
            OVER: begin
                if (bus.start) begin
                    state_d   = RUN;
                    restart_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Free counter never stops; run counter advances only while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
            rcnt <= '0;
        end else begin
            fcnt <= fcnt + CNT_W'(1);
            if (restart_d) begin
                rcnt <= '0;
            end else if (state_q == RUN) begin
                rcnt <= rcnt + CNT_W'(1);
            end
        end
    end

    // Move period shrinks with speed; mask selects the compared low bits.
    always_comb begin
        move_n_c    = SHIFT_W'(MOVE_LOG2) - SHIFT_W'(bus.speed);
        move_mask_c = ~({CNT_W{1'b1}} << move_n_c);
    end

    // Strobes fire the cycle after the counter's low bits are all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q     <= 1'b0;
            pace_q    <= 1'b0;
            game_q    <= 1'b0;
            move_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            pix_q     <= &fcnt[PIX_LOG2-1:0];
            pace_q    <= &fcnt[PACE_LOG2-1:0];
            game_q    <= (state_q == RUN) && (&rcnt[GAME_LOG2-1:0]);
            move_q    <= (state_q == RUN) && ((rcnt & move_mask_c) == move_mask_c);
            restart_q <= restart_d;
        end
    end

    assign bus.pix_tick  = pix_q;
    assign bus.pace_tick = pace_q;
    assign bus.game_tick = game_q;
    assign bus.move_tick = move_q;
    assign bus.restart   = restart_q;
    assign bus.seg_sel   = fcnt[SEG_LOG2+1:SEG_LOG2];
    assign bus.state     = state_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler using small test periods.
module tb_tick_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    tick_scheduler_if bus ();

    tick_scheduler #(
        .PIX_LOG2  (2),
        .SEG_LOG2  (3),
        .GAME_LOG2 (4),
        .MOVE_LOG2 (5),
        .PACE_LOG2 (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Free-running strobes and digit select for free-counter value f.
    task automatic check_free(input int c, input int f);
        check($sformatf("pix@%0d", c),  32'(bus.pix_tick),  32'((f > 0) && (f % 4 == 0)));
        check($sformatf("pace@%0d", c), 32'(bus.pace_tick), 32'((f > 0) && (f % 64 == 0)));
        check($sformatf("seg@%0d", c),  32'(bus.seg_sel),   32'((f / 8) % 4));
    endtask

    function automatic int exp_state(input int c);
        if (c <= 10)  return 0;
        if (c <= 104) return 1;
        if (c <= 125) return 2;
        if (c <= 136) return 1;
        if (c <= 140) return 3;
        if (c <= 172) return 1;
        if (c <= 186) return 3;
        if (c <= 240) return 1;
        return 0;
    endfunction

    function automatic bit exp_game(input int c);
        return c inside {27, 43, 59, 75, 91, 128, 157, 173, 203, 219, 235};
    endfunction

    function automatic bit exp_move(input int c);
        return c inside {43, 75, 128, 173, 191, 195, 199, 203, 219, 235};
    endfunction

    function automatic bit exp_restart(input int c);
        return c inside {11, 141, 187};
    endfunction

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.pause   = 1'b0;
        bus.collide = 1'b0;
        bus.speed   = 2'd0;
        step();
        rst = 1'b0;

        // Idle run: free strobes only; pause and collide ignored in IDLE.
        for (int c = 0; c <= 128; c++) begin
            bus.pause   = (c == 20);
            bus.collide = (c == 30);
            check_free(c, c);
            check($sformatf("state@%0d", c),   32'(bus.state),     32'd0);
            check($sformatf("game@%0d", c),    32'(bus.game_tick), 32'd0);
            check($sformatf("move@%0d", c),    32'(bus.move_tick), 32'd0);
            check($sformatf("restart@%0d", c), 32'(bus.restart),   32'd0);
            step();
        end

        rst         = 1'b1;
        bus.pause   = 1'b0;
        bus.collide = 1'b0;
        step();
        rst = 1'b0;

        // Game scenario: start, pause/resume, collide priority, exit edge,
        // speed change, then a mid-game reset at cycle 240.
        for (int c = 0; c <= 270; c++) begin
            rst         = (c == 240);
            bus.start   = (c == 10) || (c == 140) || (c == 186);
            bus.pause   = (c == 104) || (c == 125) || (c == 136) || (c == 138);
            bus.collide = (c == 136) || (c == 172);
            bus.speed   = (c >= 200) ? 2'd1 : ((c >= 186) ? 2'd3 : 2'd0);
            check_free(c, (c >= 241) ? c - 241 : c);
            check($sformatf("state@%0d", c),   32'(bus.state),     32'(exp_state(c)));
            check($sformatf("game@%0d", c),    32'(bus.game_tick), 32'(exp_game(c)));
            check($sformatf("move@%0d", c),    32'(bus.move_tick), 32'(exp_move(c)));
            check($sformatf("restart@%0d", c), 32'(bus.restart),   32'(exp_restart(c)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
